// File: rtl/start_fifo_pkg.sv
// start_fifo_pkg: shared types and helpers for the start-token shift-register FIFO.
package start_fifo_pkg;
    localparam int CNT_EMPTY = 0;
    typedef enum logic [1:0] {OCC_HOLD, OCC_PUSH, OCC_POP} occ_op_t;
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/start_fifo_srl_store.sv
// start_fifo_srl_store: shift-register storage, new word enters at index 0, read by address.
module start_fifo_srl_store #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] sreg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) sreg[i] <= sreg[i-1];
            sreg[0] <= din;
        end
    end

    assign dout = sreg[addr];
endmodule

// File: rtl/start_fifo_srl_rw.sv
// start_fifo_srl_rw: FWFT ap_fifo built on a shift register; read side tracks occupancy.
// START_FIFO_SRL_OUTREG_EN adds a head-word output register (capacity DEPTH+1).
module start_fifo_srl_rw
    import start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY_CNT = CW'(CNT_EMPTY);

    logic                  wr, rd, full_n_r, empty_n_r;
    logic [CW-1:0]         count, count_next;
    logic [ADDR_WIDTH-1:0] raddr, raddr_next;
    logic [DATA_WIDTH-1:0] sreg_dout;
    occ_op_t               op;

    start_fifo_srl_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_store (
        .clk (clk),
        .we  (wr),
        .addr(raddr),
        .din (if_din),
        .dout(sreg_dout)
    );

    assign wr        = if_write & full_n_r;
    assign if_full_n = full_n_r;

`ifdef START_FIFO_SRL_OUTREG_EN
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // Head register pulls from the array whenever it is empty or being drained.
    assign rd         = empty_n_r & (~out_valid | if_read);
    assign if_empty_n = out_valid;
    assign if_dout    = out_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (rd) begin
            out_valid <= 1'b1;
            out_data  <= sreg_dout;
        end else if (if_read) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign rd         = if_read & empty_n_r;
    assign if_empty_n = empty_n_r;
    assign if_dout    = sreg_dout;
`endif

    // raddr pins at 0 on the empty<->one transitions so it always equals max(count-1,0).
    always_comb begin
        op         = (wr && !rd) ? OCC_PUSH : (rd && !wr) ? OCC_POP : OCC_HOLD;
        count_next = (op == OCC_PUSH) ? count + 1'b1 : (op == OCC_POP) ? count - 1'b1 : count;
        raddr_next = (op == OCC_PUSH && count != EMPTY_CNT) ? raddr + 1'b1 :
                     (op == OCC_POP && raddr != '0) ? raddr - 1'b1 : raddr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= EMPTY_CNT;
            raddr     <= '0;
            full_n_r  <= 1'b1;
            empty_n_r <= 1'b0;
        end else begin
            count     <= count_next;
            raddr     <= raddr_next;
            full_n_r  <= count_next != FULL_CNT;
            empty_n_r <= count_next != EMPTY_CNT;
        end
    end
endmodule

// File: doc/start_fifo_srl_rw.md
Name: start_fifo_srl_rw

Overview:
- Complete single-clock FIFO for dataflow start-token and stream channels between HLS processes.
- Storage is a shift-register array: every accepted write shifts all entries up by one and loads the new word at index 0.
- The read side tracks occupancy and selects the oldest entry by address.
- Interface is the ap_fifo write/read pair, first-word-fall-through.

Parameters:
- DATA_WIDTH, 1, word width in bits.
- ADDR_WIDTH, 2, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 4, number of storage entries (>= 2).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high = space available.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  oldest word (FWFT).
- if_empty_n  out  1  high = if_dout valid.

Behaviour:
- Internal state:
  - count, range 0..DEPTH, width ADDR_WIDTH+1.
  - raddr, ADDR_WIDTH bits.
  - registered flags full_n_r and empty_n_r.
  - storage sreg[0..DEPTH-1], not reset.
- Reset (asynchronous, reset_n low): count=0, raddr=0, if_empty_n=0, if_full_n=1. if_dout is don't-care while if_empty_n=0.
- Write accepted: wr = if_write & if_full_n.
- Read accepted: rd = if_read & if_empty_n.
- Requests made while not accepted are ignored with no side effect: write when full, read when empty.
- On wr: sreg[i+1] <= sreg[i] for all i, and sreg[0] <= if_din.
- Occupancy update:
  - wr & !rd: count+1. raddr increments, except it stays 0 on the 0->1 transition.
  - rd & !wr: count-1. raddr decrements, except it stays 0 on the 1->0 transition.
  - wr & rd: count and raddr unchanged. The shift moves the new oldest word into raddr.
- Invariant: raddr = max(count-1, 0).
- if_dout = sreg[raddr], combinational from registers.
- Flags are registered, computed from next count:
  - if_empty_n = (count_next != 0).
  - if_full_n = (count_next != DEPTH).
- Latency: a write in cycle N makes the word visible on if_dout with if_empty_n=1 in cycle N+1.
- A read in cycle N frees a slot: if_full_n=1 in cycle N+1.
- Empty with if_write=1 and if_read=1: only the write is accepted.
- Full with both asserted: only the read is accepted; count becomes DEPTH-1.
- Reset asserted mid-operation: contents are discarded and flags return to reset values immediately (asynchronous).
- Throughput: one write and one read per cycle sustained.

Optional Feature:
- Macro: START_FIFO_SRL_OUTREG_EN.
- Defined:
  - Adds an output register stage holding the head word plus a valid bit. if_dout comes from that register.
  - The stage refills from sreg[raddr] whenever it is empty or being read this cycle and count>0.
  - if_empty_n reflects the output-register valid bit.
  - Capacity is DEPTH+1.
  - Write-to-visible latency is 2 cycles when the FIFO is empty.
  - if_full_n still reflects sreg occupancy only.
- Undefined: behaviour exactly as in Behaviour; capacity DEPTH; latency 1.

Decomposition:
- Package start_fifo_pkg:
  - occupancy-width function clog2(DEPTH)+1.
  - localparams for the empty/full count encodings.
- One sub-module is natural: start_fifo_srl_store, holding the shift array, the we/addr/din/dout port, and no reset.
- Control (count, raddr, flags, optional output register) stays in the top module.

Test Plan (DEPTH=4, DATA_WIDTH=8):
- Reset then idle -> if_empty_n=0, if_full_n=1; stays so for 10 cycles with no requests.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles -> if_dout=0x11 from cycle 1. After the fourth write, if_full_n=0. A fifth write of 0x55 is ignored.
- Full, then read 4 times -> if_dout sequence 0x11,0x22,0x33,0x44. if_full_n=1 after the first read. if_empty_n=0 after the fourth. A fifth read is ignored, count stays 0.
- Hold 2 entries (0xA0,0xA1), then simultaneous read and write of 0xA2 for 3 cycles with fresh data each cycle -> count stays 2; output order 0xA0,0xA1,0xA2,...
- Empty with if_write=1, if_read=1 for 1 cycle (data 0x7E) -> next cycle count=1, if_dout=0x7E. Full with both asserted -> count=3 and the write data is dropped.
- Fill with 3 entries, pulse reset_n low mid-cycle -> flags change without waiting for clk. After release, writing 0x5A yields if_dout=0x5A (no stale data).
- With START_FIFO_SRL_OUTREG_EN: repeat the fill/drain test -> 5 writes accepted before if_full_n=0, and 2-cycle first-word latency.
